// File: rtl/tile_cfg_pkg.sv
// Shared tile configuration types and default chain lengths.
// The array-level loader and tile_config_ctrl both derive sizes from here.
package tile_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CLB,
        LOAD_CONN,
        FLUSH,
        DONE
    } cfg_state_t;

    localparam int CHAN_WIDTH     = 4;
    localparam int NUM_BLE        = 1;
    localparam int LUT_K          = 4;
    localparam int CONN_SEL_WIDTH = 3;

    // LUT truth table plus FF-bypass and output-mux bits per BLE
    localparam int BLE_BITS = (1 << LUT_K) + 2;
    localparam int SB_BITS  = 2 * CHAN_WIDTH * CONN_SEL_WIDTH;
    localparam int CB_BITS  = CHAN_WIDTH * CONN_SEL_WIDTH;

    localparam int CLB_CHAIN_LEN_DEF  = NUM_BLE * BLE_BITS;
    localparam int CONN_CHAIN_LEN_DEF = SB_BITS + 2 * CB_BITS;
    localparam int WORD_WIDTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF      = 16;

endpackage

// File: rtl/cfg_word_serializer.sv
// Word buffer that turns accepted bitstream words into an LSB-first bit stream.
// Residual bits are dropped on discard so each chain begins on a fresh word.
module cfg_word_serializer #(
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  rem_nz,
    input  logic                  discard,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  shift,
    output logic                  bit_out
);

    logic [WORD_WIDTH-1:0] buf_q;
    logic [CNT_WIDTH-1:0]  buf_cnt;
    logic                  has_bits;
    logic                  use_buf;
    logic                  accept;

    assign has_bits  = (buf_cnt != '0);
    assign din_ready = active && !has_bits && rem_nz;
    assign accept    = din_valid && din_ready;
    assign use_buf   = active && has_bits && rem_nz;
    assign shift     = use_buf || accept;
    assign bit_out   = use_buf ? buf_q[0] : din[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            buf_cnt <= '0;
        end else if (discard) begin
            buf_q   <= '0;
            buf_cnt <= '0;
        end else if (use_buf) begin
            buf_q   <= buf_q >> 1;
            buf_cnt <= buf_cnt - CNT_WIDTH'(1);
        end else if (accept) begin
            buf_q   <= din >> 1;
            buf_cnt <= CNT_WIDTH'(WORD_WIDTH - 1);
        end
    end

endmodule

// File: rtl/tile_config_ctrl.sv
// Tile configuration sequencer: loads the CLB chain, then the connection
// chain, from a word stream, with registered scan outputs.
module tile_config_ctrl
    import tile_cfg_pkg::*;
#(
    parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int CLB_CHAIN_LEN  = CLB_CHAIN_LEN_DEF,
    parameter int CONN_CHAIN_LEN = CONN_CHAIN_LEN_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  clb_scan_in,
    output logic                  clb_scan_en,
    output logic                  conn_scan_in,
    output logic                  conn_scan_en,
    output logic                  busy,
    output logic                  done
);

    cfg_state_t           state, state_n;
    logic [CNT_WIDTH-1:0] rem, rem_n;
    logic                 clb_in_n, clb_en_n;
    logic                 conn_in_n, conn_en_n;
    logic                 done_n;
    logic                 load;
    logic                 shift;
    logic                 bit_out;
    logic                 last;
    logic                 discard;

    assign load    = (state == LOAD_CLB) || (state == LOAD_CONN);
    assign last    = shift && (rem == CNT_WIDTH'(1));
    assign discard = abort || last;
    assign busy    = load || (state == FLUSH);

    cfg_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .active    (load),
        .rem_nz    (rem != '0),
        .discard   (discard),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .shift     (shift),
        .bit_out   (bit_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            clb_scan_in  <= 1'b0;
            clb_scan_en  <= 1'b0;
            conn_scan_in <= 1'b0;
            conn_scan_en <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            rem          <= rem_n;
            clb_scan_in  <= clb_in_n;
            clb_scan_en  <= clb_en_n;
            conn_scan_in <= conn_in_n;
            conn_scan_en <= conn_en_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        rem_n     = rem;
        clb_in_n  = clb_scan_in;
        clb_en_n  = 1'b0;
        conn_in_n = conn_scan_in;
        conn_en_n = 1'b0;
        done_n    = done;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = LOAD_CLB;
                    rem_n   = CNT_WIDTH'(CLB_CHAIN_LEN);
                    done_n  = 1'b0;
                end
            end
            LOAD_CLB: begin
                if (shift) begin
                    clb_en_n = 1'b1;
                    clb_in_n = bit_out;
                    rem_n    = rem - CNT_WIDTH'(1);
                    if (last) begin
                        state_n = LOAD_CONN;
                        rem_n   = CNT_WIDTH'(CONN_CHAIN_LEN);
                    end
                end
            end
            LOAD_CONN: begin
                if (shift) begin
                    conn_en_n = 1'b1;
                    conn_in_n = bit_out;
                    rem_n     = rem - CNT_WIDTH'(1);
                    if (last) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // abort outranks start and any in-flight shift
        if (abort) begin
            state_n   = IDLE;
            rem_n     = '0;
            clb_en_n  = 1'b0;
            conn_en_n = 1'b0;
            done_n    = 1'b0;
        end
    end

endmodule

// File: doc/tile_config_ctrl.md
Name: tile_config_ctrl

Overview:
Configuration sequencer for one FPGA tile's two scan chains: the CLB chain (BLE LUT/mux bits) and the connection chain (switch block, then top CB, then right CB).
- Accepts bitstream words over a valid/ready stream.
- Serializes each word LSB-first.
- Drives each chain's scan_in/scan_en with exact per-chain bit counts: CLB chain first, then connection chain.
- Signals completion.
- Sits between the off-array bitstream loader and a tile's clb_scan_* / conn_scan_* pins.

Parameters:
WORD_WIDTH, 8, bitstream word width in bits
CLB_CHAIN_LEN, 18, number of bits in the CLB scan chain
CONN_CHAIN_LEN, 48, number of bits in the connection scan chain (SB + CB top + CB right)
CNT_WIDTH, 16, width of internal bit counters; must hold max(CLB_CHAIN_LEN, CONN_CHAIN_LEN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a configuration pass
abort  in  1  synchronous abort; return to idle
din  in  WORD_WIDTH  bitstream word
din_valid  in  1  din holds a valid word
din_ready  out  1  controller accepts din this cycle
clb_scan_in  out  1  serial bit to CLB chain
clb_scan_en  out  1  shift enable for CLB chain
conn_scan_in  out  1  serial bit to connection chain
conn_scan_en  out  1  shift enable for connection chain
busy  out  1  pass in progress (LOAD_CLB, LOAD_CONN, FLUSH)
done  out  1  pass completed; held until next start

Behaviour:
- Reset (async): state=IDLE; buf=0, buf_cnt=0, rem=0; all outputs 0.
- All scan outputs are registered. A bit presented with scan_en=1 in cycle k shifts into the chain at the end of cycle k.
- States: IDLE, LOAD_CLB, LOAD_CONN, FLUSH, DONE.
- IDLE/DONE, start=1:
  - next state LOAD_CLB, rem<=CLB_CHAIN_LEN, done<=0.
  - start in any other state is ignored.
- din_ready is combinational: (state is LOAD_CLB or LOAD_CONN) && buf_cnt==0 && rem!=0. Accept = din_valid && din_ready.
- Each cycle in LOAD_x, the active chain is x. Only that chain's scan_en may be 1, and the other chain's scan_en=0.
  - buf_cnt>0: shift buf[0] out, buf>>=1, buf_cnt--, rem--.
  - else if accept: shift din[0] out, buf<=din>>1, buf_cnt<=WORD_WIDTH-1, rem--.
  - else (stall): scan_en<=0, scan_in holds.
  - A "shift" registers the bit onto x_scan_in and sets x_scan_en<=1.
- No bubble with a continuously valid stream: one bit per cycle.
- Chain end (the shift that drives rem to 0):
  - Remaining buffered bits are discarded; buf_cnt<=0.
  - Each chain starts on a fresh word.
  - LOAD_CLB -> LOAD_CONN with rem<=CONN_CHAIN_LEN.
  - LOAD_CONN -> FLUSH.
- FLUSH: one cycle; the last conn bit is shifting. Scan_en outputs go to 0, then -> DONE.
- done=1 in DONE (first asserted in the cycle after the last conn_scan_en=1 cycle). busy=0 in IDLE/DONE.
- abort=1 in any state: next edge state=IDLE, buf/buf_cnt/rem cleared, both scan_en<=0, done<=0. abort has priority over start.
- Async reset mid-pass: scan_en drop immediately. The chains hold partial contents; a full pass is required afterwards.
- Total cycles for an unstalled pass: CLB_CHAIN_LEN + CONN_CHAIN_LEN shift cycles, +1 FLUSH. Minimum words consumed: ceil(CLB/W) + ceil(CONN/W).

Decomposition:
- Shared package tile_cfg_pkg holds:
  - state enum (IDLE, LOAD_CLB, LOAD_CONN, FLUSH, DONE)
  - default chain-length constants derived from tile parameters (channel width 4, 1 BLE, conn sel width 3), so the array-level loader and this block agree.
- One natural sub-module: cfg_word_serializer. It holds buf, buf_cnt, the load/shift/discard controls and the din_ready term. The FSM and rem counter stay in the top module.

Test Plan (WORD_WIDTH=8, CLB_CHAIN_LEN=5, CONN_CHAIN_LEN=12):
- Reset: assert rst mid-cycle -> all outputs 0 immediately; state IDLE; din_ready=0.
- Full pass, no stalls: start, then words 0x15, 0xA5, 0x03 continuously valid.
  - CLB chain sees 1,0,1,0,1 with clb_scan_en high for exactly 5 consecutive cycles.
  - conn chain sees 1,0,1,0,0,1,0,1,1,1,0,0 with conn_scan_en high for 12 consecutive cycles.
  - done rises 1 cycle after the last conn_scan_en; 3 words consumed.
- Stalls: same pass with din_valid low for 3 cycles before word 0x03 -> conn_scan_en low for exactly those 3 cycles; bit sequence unchanged; done 3 cycles later than unstalled.
- Abort: abort during the 4th conn bit -> next cycle both scan_en=0, busy=0, done=0, din_ready=0. A following start plus 3 words completes normally.
- Start handling: start during LOAD_CONN -> ignored, bit count unchanged. start in DONE -> done drops next cycle and a new pass begins in LOAD_CLB.
- Async reset at the 2nd CLB bit -> outputs 0 without a clock edge. After release, start plus full stream gives a correct 5+12-bit pass.
